// File: rtl/mux_timer_display.sv
// Elapsed-time counter (SS/MM/HH-style digit pairs) scanned onto one shared 7-segment bus.
// Scan outputs are registered one cycle behind the index; single-cycle control pulses, no backpressure.
module mux_timer_display #(
  parameter int          NUM_DIG  = 4,
  parameter int          TICK_DIV = 1000000,
  parameter int          SCAN_DIV = 1000,
  parameter int          BLANK_LZ = 1,
  parameter logic [7:0]  DP_MASK  = 8'b0000_0100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_tgl,
  input  logic       clr,
  input  logic       hold_tgl,
  output logic [7:0] seg_com,
  output logic [7:0] seg_data,
  output logic       running,
  output logic       overflow
);

  localparam int             TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int             SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]  SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [2:0]     IDX_LAST  = 3'(NUM_DIG - 1);

  logic [TW-1:0]             tick_cnt;
  logic                      tick;
  logic                      hold;
  logic [NUM_DIG-1:0][3:0]   digits;
  logic [NUM_DIG-1:0][3:0]   snap;
  logic [NUM_DIG-1:0][3:0]   disp;
  logic [NUM_DIG-1:0]        at_max;
  logic [NUM_DIG-1:0]        inc;
  logic [NUM_DIG-1:0]        blank;
  logic                      wrap_all;
  logic [SW-1:0]             scan_cnt;
  logic [2:0]                scan_idx;
  logic [3:0]                cur_val;
  logic                      cur_blank;
  logic                      cur_dp;
  logic [7:0]                com_nxt;
  logic [7:0]                data_nxt;

  // Even positions are decimal units (0..9), odd positions are tens of a 60-base pair (0..5).
  function automatic logic [3:0] dig_max(input int i);
    return (i % 2 == 0) ? 4'd9 : 4'd5;
  endfunction

  function automatic logic [7:0] seg_enc(input logic [3:0] v);
    case (v)
      4'd0:    return 8'hFC;
      4'd1:    return 8'h60;
      4'd2:    return 8'hDA;
      4'd3:    return 8'hF2;
      4'd4:    return 8'h66;
      4'd5:    return 8'hB6;
      4'd6:    return 8'hBE;
      4'd7:    return 8'hE0;
      4'd8:    return 8'hFE;
      4'd9:    return 8'hF6;
      default: return 8'h00;
    endcase
  endfunction

  assign tick = running && (tick_cnt == TICK_LAST);

  // Ripple carry resolved within one cycle: digit i steps when every lower digit is at max.
  always_comb begin : carry_chain
    logic c;
    c      = tick;
    at_max = '0;
    inc    = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      at_max[i] = (digits[i] == dig_max(i));
      inc[i]    = c;
      c         = c && at_max[i];
    end
    wrap_all = c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      running  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      running  <= running ^ run_tgl;
      overflow <= wrap_all && !clr;
      if (clr) begin
        tick_cnt <= '0;
      end else if (running) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits <= '0;
    end else if (clr) begin
      digits <= '0;
    end else begin
      for (int i = 0; i < NUM_DIG; i++) begin
        if (inc[i]) begin
          digits[i] <= at_max[i] ? 4'd0 : digits[i] + 4'd1;
        end
      end
    end
  end

  // Snapshot is taken only on entry to hold; clr never touches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= 1'b0;
      snap <= '0;
    end else begin
      hold <= hold ^ hold_tgl;
      if (hold_tgl && !hold) begin
        snap <= digits;
      end
    end
  end

  assign disp = hold ? snap : digits;

  always_comb begin : lz_blank
    logic z;
    z     = 1'b1;
    blank = '0;
    for (int i = NUM_DIG - 1; i >= 1; i--) begin
      z        = z && (disp[i] == 4'd0);
      blank[i] = z && (BLANK_LZ != 0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= 3'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? 3'd0 : scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_comb begin
    cur_val   = 4'd0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (scan_idx == 3'(i)) begin
        cur_val   = disp[i];
        cur_blank = blank[i];
        cur_dp    = DP_MASK[i];
      end
    end
    com_nxt                 = 8'hFF;
    com_nxt[3'd7 - scan_idx] = 1'b0;
    data_nxt = cur_blank ? 8'h00 : (seg_enc(cur_val) | {7'd0, cur_dp});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_com  <= 8'hFF;
      seg_data <= 8'h00;
    end else begin
      seg_com  <= com_nxt;
      seg_data <= data_nxt;
    end
  end

endmodule

// File: doc/mux_timer_display.md
Name: mux_timer_display

Overview:
- Parametrised successor to the two-digit scanned display: an NUM_DIG-digit elapsed-time counter (SS, MM, ... pairs) driving one shared 8-bit segment bus through a time-multiplexed common-select.
- Adds run/stop, clear, display hold (lap), leading-zero blanking and overflow flag.
- Sits between the board push-button conditioners (single-cycle pulses) and the 8-digit 7-segment connector.

Parameters:
- NUM_DIG, 4, number of displayed digits, 2..8; digit 0 = least significant.
- TICK_DIV, 1000000, clk cycles per count increment of digit 0; >= 2.
- SCAN_DIV, 1000, clk cycles each digit stays selected before the scanner advances; >= 1.
- BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 never blanked).
- DP_MASK, 8'b0000_0100, bit i = 1 lights the decimal point on digit i.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run_tgl  in  1  one-cycle pulse; toggles running
- clr  in  1  one-cycle pulse; zeroes count
- hold_tgl  in  1  one-cycle pulse; toggles display freeze
- seg_com  out  8  digit select, active-low; digit i on bit (7-i); unused bits held 1
- seg_data  out  8  segments {a,b,c,d,e,f,g,dp}, bit7 = a, active-high
- running  out  1  1 while counting
- overflow  out  1  one-cycle pulse on full wrap

Behaviour:
- Reset (async, rst=1): all digits 0, tick and scan counters 0, scan index 0, running=0, hold=0, overflow=0, seg_com=8'hFF, seg_data=8'h00. First scan output appears after release.
- Digit moduli: even index digits count 0..9, odd index 0..5 (SS, MM, HH-style pairs).
- Tick counter: increments only when running=1; on reaching TICK_DIV-1 it returns to 0 and issues an internal tick that cycle.
- Digit chain: on tick, digit 0 increments; digit i+1 increments in the same cycle that digit i wraps to 0 (ripple carry, single cycle, no clock-enable chains across cycles).
- Full wrap (all digits at max when tick fires): all digits become 0, overflow=1 for exactly that one cycle; counting continues.
- run_tgl: running <= ~running next cycle; tick counter keeps its value across stop/start (no lost fraction).
- clr: digits and tick counter zeroed next cycle; running unchanged. clr and a tick in the same cycle: clr wins, no increment, no overflow. clr with run_tgl same cycle: both apply.
- hold_tgl: hold <= ~hold. Entering hold snapshots the current digits (value the cycle hold_tgl is sampled) into a display register; while hold=1 the display shows the snapshot and counting continues. Leaving hold returns to live digits. clr while held zeroes live count only.
- Scanner: scan counter 0..SCAN_DIV-1 runs continuously after reset regardless of running; at terminal value the index advances 0,1,...,NUM_DIG-1,0.
- Outputs registered: seg_com/seg_data reflect the index one cycle after it changes. Exactly one seg_com bit low at all times after the first post-reset cycle.
- Encoding: standard 0-9 patterns (0 -> 8'hFC, 1 -> 8'h60, 5 -> 8'hB6, 8 -> 8'hFE), dp bit = DP_MASK[i].
- Blanking (BLANK_LZ=1): digit i>0 shows 8'h00 (including dp) when it and all higher digits are 0.
- Counter widths: digits 4 bits each; tick counter ceil(log2(TICK_DIV)); scan counter ceil(log2(SCAN_DIV)); index 3 bits.
- rst asserted mid-operation clears everything immediately, regardless of clk.

Test Plan:
- Reset/idle (NUM_DIG=4, SCAN_DIV=2): rst pulse, no run -> seg_com cycles 7F,BF,DF,EF every 2 clk; digit0 seg_data=8'hFC, digits 1-3 = 8'h00 (blanked), dp never lit.
- Counting (TICK_DIV=4): run_tgl then 4*60 clk -> digits read 0,0,1,0 (01:00 form), digit2 shows 8'h60 with dp, i.e. 8'h61.
- Overflow: preload by running 4*3600 clk -> digits 0,0,0,0 and overflow high exactly 1 cycle at the wrap tick.
- Stop/resume: run_tgl after 6 clk, wait 100, run_tgl -> next tick 2 clk later (tick counter retained at 2).
- Hold: hold_tgl at count 05, run 40 more ticks -> display stays 05; hold_tgl -> display shows 45.
- Simultaneity/reset: clr on same cycle as tick -> count 00, overflow 0; assert rst mid-scan -> seg_com=8'hFF, running=0 immediately, without a clk edge.
